// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants.
// Writeback source encodings and instruction field positions.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int RD_LSB    = 7;
  localparam int RD_MSB    = 11;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_IMM = 2'b10,
    WB_PC4 = 2'b11
  } wb_sel_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Integer register file: two combinational reads, one write, x0 hardwired.
// Define WB_BYPASS_EN for write-through of the same-cycle write.
module regfile_2r1w
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [REG_IDX_W-1:0] raddr1,
  input  logic [REG_IDX_W-1:0] raddr2,
  output logic [XLEN-1:0]      rdata1,
  output logic [XLEN-1:0]      rdata2
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  function automatic logic [XLEN-1:0] rd_port(
    input logic [REG_IDX_W-1:0] a
  );
    logic [XLEN-1:0] v;
    v = (a == '0) ? '0 : mem[a];
`ifdef WB_BYPASS_EN
    if (we && a != '0 && a == waddr) v = wdata;
`endif
    return v;
  endfunction

  always_comb begin
    rdata1 = rd_port(raddr1);
    rdata2 = rd_port(raddr2);
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: source mux, qualified regfile write, instret, trap capture.
// Optional WB_BYPASS_EN makes the read ports write-through.
module wb_regfile
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  logic             memtoreg,
  input  logic             regwrite,
  input  logic [1:0]       regin,
  input  logic [XLEN-1:0]  ALUout,
  input  logic [XLEN-1:0]  Rdata,
  input  logic [XLEN-1:0]  immgen,
  input  logic [XLEN-1:0]  PC_plus4,
  input  logic [31:0]      inst_data,
  input  logic             invalid,
  input  logic             clr_trap,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [CNT_W-1:0] instret,
  output logic             trap_pending,
  output logic [31:0]      trap_inst,
  output logic [XLEN-1:0]  trap_pc
);

  wb_sel_t sel;
  logic    retire;
  logic    capture;

  assign sel   = memtoreg ? WB_MEM : wb_sel_t'(regin);
  assign wb_rd = inst_data[RD_MSB:RD_LSB];

  always_comb begin
    wb_data = ALUout;
    unique case (sel)
      WB_ALU: wb_data = ALUout;
      WB_MEM: wb_data = Rdata;
      WB_IMM: wb_data = immgen;
      WB_PC4: wb_data = PC_plus4;
    endcase
  end

  assign wb_we  = wb_valid & regwrite & ~invalid & (wb_rd != '0);
  assign retire = wb_valid & ~invalid;
  // A new illegal instruction beats a same-cycle clear.
  assign capture = wb_valid & invalid & (~trap_pending | clr_trap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_pending <= 1'b0;
      trap_inst    <= '0;
      trap_pc      <= '0;
    end else if (capture) begin
      trap_pending <= 1'b1;
      trap_inst    <= inst_data;
      trap_pc      <= PC_plus4 - XLEN'(4);
    end else if (clr_trap) begin
      trap_pending <= 1'b0;
    end
  end

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: spec-level model plus directed vectors.
// Build with WB_BYPASS_EN to check the write-through variant.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid, memtoreg, regwrite, invalid, clr_trap;
  logic [1:0]  regin;
  logic [31:0] ALUout, Rdata, immgen, PC_plus4, inst_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [63:0] instret;
  logic        trap_pending;
  logic [31:0] trap_inst, trap_pc;

  int n_chk = 0;
  int n_fail = 0;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .memtoreg(memtoreg),
    .regwrite(regwrite), .regin(regin), .ALUout(ALUout), .Rdata(Rdata),
    .immgen(immgen), .PC_plus4(PC_plus4), .inst_data(inst_data),
    .invalid(invalid), .clr_trap(clr_trap), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_data(wb_data), .wb_we(wb_we), .wb_rd(wb_rd), .instret(instret),
    .trap_pending(trap_pending), .trap_inst(trap_inst), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  // Behavioural model
  logic [31:0] m_regs [32];
  logic [63:0] m_cnt;
  logic        m_pend;
  logic [31:0] m_tinst, m_tpc;

  function automatic logic [31:0] m_wbval();
    if (memtoreg) return Rdata;
    case (regin)
      2'd0: return ALUout;
      2'd1: return Rdata;
      2'd2: return immgen;
      default: return PC_plus4;
    endcase
  endfunction

  function automatic logic m_we();
    return wb_valid && regwrite && !invalid && inst_data[11:7] != 5'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (m_we() && a == inst_data[11:7]) return m_wbval();
`endif
    return m_regs[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
      m_cnt   <= 64'd0;
      m_pend  <= 1'b0;
      m_tinst <= 32'd0;
      m_tpc   <= 32'd0;
    end else begin
      if (m_we()) m_regs[inst_data[11:7]] <= m_wbval();
      if (wb_valid && !invalid) m_cnt <= m_cnt + 64'd1;
      if (wb_valid && invalid && (!m_pend || clr_trap)) begin
        m_pend  <= 1'b1;
        m_tinst <= inst_data;
        m_tpc   <= PC_plus4 - 32'd4;
      end else if (clr_trap) begin
        m_pend <= 1'b0;
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("m_rs1", rs1_data, m_read(rs1_addr));
    check("m_rs2", rs2_data, m_read(rs2_addr));
    check("m_wb_data", wb_data, m_wbval());
    check("m_wb_we", wb_we, m_we());
    check("m_wb_rd", wb_rd, inst_data[11:7]);
    check("m_instret", instret, m_cnt);
    check("m_trap_pending", trap_pending, m_pend);
    check("m_trap_inst", trap_inst, m_tinst);
    check("m_trap_pc", trap_pc, m_tpc);
  end

  function automatic logic [31:0] ins(input logic [4:0] rd);
    return {20'h0, rd, 7'h33};
  endfunction

  task automatic idle();
    wb_valid = 0; memtoreg = 0; regwrite = 0; regin = 2'd0;
    ALUout = 0; Rdata = 0; immgen = 0; PC_plus4 = 0;
    inst_data = 0; invalid = 0; clr_trap = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; rs1_addr = 0; rs2_addr = 0;
    idle();
    repeat (2) @(posedge clk);
    #3;
    check("reset_instret", instret, 64'd0);
    check("reset_trap", trap_pending, 1'b0);
    #1 rst_n = 1;
    tick();

    wb_valid = 1; regwrite = 1; regin = 2'd0;
    ALUout = 32'hDEADBEEF; inst_data = ins(5'd5);
    #3 check("alu_wb_data", wb_data, 32'hDEADBEEF);
    check("alu_we", wb_we, 1'b1);
    tick(); idle(); rs1_addr = 5;
    #3 check("alu_read", rs1_data, 32'hDEADBEEF);
    check("alu_instret", instret, 64'd1);

    tick();
    wb_valid = 1; regwrite = 1; regin = 2'd3;
    PC_plus4 = 32'h104; inst_data = ins(5'd1);
    tick();
    memtoreg = 1; regin = 2'd2; Rdata = 32'h55; immgen = 32'hAA;
    inst_data = ins(5'd2);
    #3 check("m2r_override", wb_data, 32'h55);
    tick(); idle(); rs1_addr = 1; rs2_addr = 2;
    #3 check("pc4_read", rs1_data, 32'h104);
    check("mem_read", rs2_data, 32'h55);

    tick();
    wb_valid = 1; regwrite = 1; ALUout = 32'hFFFF_FFFF;
    inst_data = ins(5'd0); rs1_addr = 0;
    #3 check("x0_we", wb_we, 1'b0);
    tick(); idle();
    #3 check("x0_read", rs1_data, 32'd0);
    check("x0_instret", instret, 64'd4);

    tick();
    regwrite = 1; ALUout = 32'h77; inst_data = ins(5'd6);
    tick(); idle(); rs1_addr = 6;
    #3 check("bubble_read", rs1_data, 32'd0);
    check("bubble_instret", instret, 64'd4);

    tick();
    wb_valid = 1; regwrite = 1; invalid = 1;
    inst_data = 32'hFFFF_FFFF; PC_plus4 = 32'h200; rs1_addr = 31;
    #3 check("inv_we", wb_we, 1'b0);
    tick();
    inst_data = 32'h0000_0193; PC_plus4 = 32'h300; rs2_addr = 3;
    #3 check("trap_pending", trap_pending, 1'b1);
    check("trap_pc", trap_pc, 32'h1FC);
    check("trap_inst", trap_inst, 32'hFFFF_FFFF);
    check("inv_instret", instret, 64'd4);
    tick(); idle();
    #3 check("trap_keep_inst", trap_inst, 32'hFFFF_FFFF);
    check("trap_keep_pc", trap_pc, 32'h1FC);
    check("inv_x31", rs1_data, 32'd0);
    check("inv_x3", rs2_data, 32'd0);

    clr_trap = 1;
    tick(); idle();
    #3 check("clr_trap", trap_pending, 1'b0);
    wb_valid = 1; invalid = 1; inst_data = 32'hA; PC_plus4 = 32'h400;
    tick();
    clr_trap = 1; inst_data = 32'hB; PC_plus4 = 32'h500;
    tick(); idle();
    #3 check("clr_race_pend", trap_pending, 1'b1);
    check("clr_race_inst", trap_inst, 32'hB);
    check("clr_race_pc", trap_pc, 32'h4FC);

    wb_valid = 1; regwrite = 1; ALUout = 32'h1234;
    inst_data = ins(5'd7); rs2_addr = 7;
`ifdef WB_BYPASS_EN
    #3 check("same_cycle_rd", rs2_data, 32'h1234);
`else
    #3 check("same_cycle_rd", rs2_data, 32'd0);
`endif
    tick(); idle();
    #3 check("after_write_rd", rs2_data, 32'h1234);

    tick();
    wb_valid = 1; regwrite = 1; ALUout = 32'h99; inst_data = ins(5'd9);
    rs1_addr = 5; rs2_addr = 1;
    #1 rst_n = 0;
    #1 check("arst_rs1", rs1_data, 32'd0);
    check("arst_rs2", rs2_data, 32'd0);
    check("arst_instret", instret, 64'd0);
    check("arst_trap", trap_pending, 1'b0);
    tick(); idle(); rst_n = 1; rs1_addr = 9;
    #3 check("arst_lost_write", rs1_data, 32'd0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
